prescaled_counter: RTL and testbench

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

---
 rtl/counter_pkg.sv | 18 +
 rtl/tick_gen.sv | 50 +++++
 rtl/prescaled_counter.sv | 95 +++++++++
 tb/tb_prescaled_counter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the prescaled up/down counter.
// Mode encoding and prescaler sizing live here so both levels agree.
package counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } mode_e;

    // A divide-by-1 prescaler still needs a 1-bit register to exist.
    function automatic int presc_width(input int div);
        if (div <= 1) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated prescaler: emits one tick every PRESC_DIV enabled cycles.
// clear restarts the period without waiting for reset.
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESC_DIV = 25_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = presc_width(PRESC_DIV);
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    if (PRESC_DIV < 1) begin : g_bad_div
        $error("tick_gen: PRESC_DIV must be >= 1");
    end

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          at_last;

    assign at_last = (presc_q == LAST);
    assign tick    = enable && at_last;

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (enable) begin
            if (at_last) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down modulo counter stepped by a prescaled tick, with wrap or
// saturate at the terminal value, clamped parallel load and a tc pulse.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 10,
    parameter longint unsigned MODULUS   = (64'd1 << WIDTH),
    parameter int              PRESC_DIV = 25_000_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("prescaled_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("prescaled_counter: MODULUS must be 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;
    mode_e            mode_s;

    tick_gen #(
        .PRESC_DIV(PRESC_DIV)
    ) u_tick_gen (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .enable  (enable),
        .clear   (load),
        .tick    (tick)
    );

    assign mode_s = mode_e'(mode);

    always_comb begin
        at_term = 1'b0;
        if (up) begin
            at_term = (count_q == MAX_VAL);
        end else begin
            at_term = (count_q == '0);
        end
    end

    assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    // Load wins over tick; up and mode only matter on tick edges.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (tick) begin
            tc_d = at_term;
            if (at_term) begin
                if (mode_s == WRAP) begin
                    count_d = up ? '0 : MAX_VAL;
                end
            end else if (up) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed + random bench for prescaled_counter in two configurations
// (4/10/3 and 4/16/1) sharing one stimulus stream and one clock.
module tb_prescaled_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, mode, ld;
    logic [3:0] lv;
    logic [3:0] count0, count1;
    logic       tick0, tick1, tc0, tc1;

    int tests = 0;
    int fails = 0;

    int P[2]  = '{3, 1};
    int MD[2] = '{10, 16};
    int m_cnt[2];
    int m_ph[2];
    int m_tc[2];

    int  tc0_seen, tc1_seen, ticks0, n;
    logic obs_tick0;

    always #5 clk = ~clk;

    prescaled_counter #(
        .WIDTH(4), .MODULUS(10), .PRESC_DIV(3)
    ) dut (
        .CLOCK_50(clk), .reset(rst), .enable(en), .up(up), .mode(mode),
        .load(ld), .load_value(lv), .count(count0), .tick(tick0), .tc(tc0)
    );

    prescaled_counter #(
        .WIDTH(4), .MODULUS(16), .PRESC_DIV(1)
    ) dut1 (
        .CLOCK_50(clk), .reset(rst), .enable(en), .up(up), .mode(mode),
        .load(ld), .load_value(lv), .count(count1), .tick(tick1), .tc(tc1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_tick(input int i);
        return (en && m_ph[i] == P[i] - 1) ? 1 : 0;
    endfunction

    // Behavioural rules: load clamps, ticks step modulo MD unless saturating.
    task automatic model_edge(input int i, input int mt);
        int at;
        if (rst) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0;
        end else if (ld) begin
            m_cnt[i] = (int'(lv) > MD[i] - 1) ? MD[i] - 1 : int'(lv);
            m_ph[i] = 0; m_tc[i] = 0;
        end else begin
            m_tc[i] = 0;
            if (mt != 0) begin
                at = up ? (m_cnt[i] == MD[i] - 1) : (m_cnt[i] == 0);
                m_tc[i] = at;
                if (!(at != 0 && mode))
                    m_cnt[i] = (m_cnt[i] + (up ? 1 : MD[i] - 1)) % MD[i];
            end
            if (en) m_ph[i] = (m_ph[i] + 1) % P[i];
        end
    endtask

    task automatic step();
        int mt0, mt1;
        #2;
        mt0 = model_tick(0);
        mt1 = model_tick(1);
        chk("tick0", int'(tick0), mt0);
        chk("tick1", int'(tick1), mt1);
        obs_tick0 = tick0;
        if (tick0) ticks0++;
        @(posedge clk);
        model_edge(0, mt0);
        model_edge(1, mt1);
        #1;
        chk("count0", int'(count0), m_cnt[0]);
        chk("tc0", int'(tc0), m_tc[0]);
        chk("count1", int'(count1), m_cnt[1]);
        chk("tc1", int'(tc1), m_tc[1]);
        if (tc0) tc0_seen++;
        if (tc1) tc1_seen++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; up = 1'b1; mode = 1'b0; ld = 1'b1; lv = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0;
        end
        chk("reset_count0", int'(count0), 0);
        chk("reset_tc0", int'(tc0), 0);
        chk("reset_count1", int'(count1), 0);

        // Count up with wrap; dut1 ticks every cycle.
        rst = 1'b0; ld = 1'b0; en = 1'b1; up = 1'b1; mode = 1'b0;
        tc0_seen = 0; tc1_seen = 0; ticks0 = 0;
        repeat (20) step();
        chk("fast_tc_once", tc1_seen, 1);
        chk("fast_count20", int'(count1), 4);
        repeat (13) step();
        chk("wrap_tc_once", tc0_seen, 1);
        chk("ticks_in_33", ticks0, 11);
        chk("count_after_33", int'(count0), 1);

        // Saturate down at 0.
        ld = 1'b1; lv = 4'd0; up = 1'b0; mode = 1'b1;
        step();
        ld = 1'b0; tc0_seen = 0;
        repeat (6) step();
        chk("sat_hold0", int'(count0), 0);
        chk("sat_tc_pulses", tc0_seen, 2);

        // Clamped load, then load colliding with a tick.
        ld = 1'b1; lv = 4'd13;
        step();
        ld = 1'b0;
        chk("load_clamp", int'(count0), 9);
        step(); step();
        ld = 1'b1; lv = 4'd4;
        step();
        chk("load_on_tick", int'(count0), 4);
        chk("load_on_tick_tc", int'(tc0), 0);
        ld = 1'b0; up = 1'b1; mode = 1'b0;
        n = 0;
        do begin step(); n++; end while (!obs_tick0 && n < 10);
        chk("tick_after_load", n, 3);

        // Freeze with enable low at prescaler=1.
        step();
        en = 1'b0;
        repeat (5) step();
        chk("frozen_count", int'(count0), 5);
        en = 1'b1;
        n = 0;
        do begin step(); n++; end while (!obs_tick0 && n < 10);
        chk("tick_after_reenable", n, 2);

        // Reset mid-period overriding load.
        ld = 1'b1; lv = 4'd7;
        step();
        ld = 1'b0;
        step(); step();
        chk("pre_reset_count", int'(count0), 7);
        rst = 1'b1; ld = 1'b1; lv = 4'd3;
        step();
        chk("midreset_count", int'(count0), 0);
        chk("midreset_tc", int'(tc0), 0);
        rst = 1'b0; ld = 1'b0;
        n = 0;
        do begin step(); n++; end while (!obs_tick0 && n < 10);
        chk("tick_after_reset", n, 3);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 49) == 0);
            ld   = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            mode = $urandom_range(0, 1) != 0;
            lv   = 4'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
